// File: rtl/branch_pred_ctrl.sv
// 2-bit saturating branch direction predictor with D->E->M prediction tracking and M-stage training.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_pred_ctrl #(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         GHR_W    = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pcD,
    input  logic        branchD,
    input  logic        stallE,
    input  logic        flushE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        branchM,
    input  logic        actual_takeM,
    output logic        pred_takeD,
    output logic        succM,
    output logic        init_busy
);
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic             predTake;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } track_t;

    state_t           state;
    logic [IDX_W-1:0] initCnt;
    logic [1:0]       pht [DEPTH];
    track_t           trkE, trkM;
    logic [IDX_W-1:0] idxD;
    logic             running;
    logic             train;
    logic [1:0]       curCnt, nextCnt;
    logic             unusedPc;

    assign running  = (state == RUN);
    assign unusedPc = ^{pcD[31:IDX_W+2], pcD[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr;

    assign idxD = pcD[IDX_W+1:2] ^ IDX_W'(ghr);

    // History survives INIT; only reset clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ghr <= '0;
        else if (train)
            ghr <= GHR_W'({ghr, actual_takeM});
    end
`else
    assign idxD = pcD[IDX_W+1:2];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT;
            initCnt   <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            initCnt <= initCnt + 1'b1;
            if (initCnt == '1) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    assign pred_takeD = branchD & running & pht[idxD][1];

    // Stalled M never trains, so a branch held in M updates once, on release.
    assign train  = running & branchM & trkM.valid & ~stallM;
    assign curCnt = pht[trkM.idx];

    always_comb begin
        nextCnt = curCnt;
        if (actual_takeM) begin
            if (curCnt != 2'b11) nextCnt = curCnt + 2'b01;
        end else begin
            if (curCnt != 2'b00) nextCnt = curCnt - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT)
            pht[initCnt] <= INIT_CNT;
        else if (train)
            pht[trkM.idx] <= nextCnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trkE <= '0;
            trkM <= '0;
        end else begin
            if (flushE)
                trkE <= '0;
            else if (!stallE)
                trkE <= {pred_takeD, idxD, branchD & running};

            if (flushM)
                trkM <= '0;
            else if (!stallM)
                trkM <= trkE;
        end
    end

    assign succM = ~(branchM & trkM.valid) | (trkM.predTake == actual_takeM);

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed plus randomized bench for branch_pred_ctrl against a table-level reference model.
module tb_branch_pred_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pcD = '0;
    logic        branchD = 0, stallE = 0, flushE = 0, stallM = 0, flushM = 0;
    logic        branchM = 0, actual_takeM = 0;
    logic        pred_takeD, succM, init_busy;

    int checks = 0;
    int errors = 0;

    branch_pred_ctrl dut (
        .clk(clk), .resetn(resetn), .pcD(pcD), .branchD(branchD),
        .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
        .branchM(branchM), .actual_takeM(actual_takeM),
        .pred_takeD(pred_takeD), .succM(succM), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Reference model: counters as plain ints, predictions carried as records.
    typedef struct { bit p; int idx; bit v; } trk_t;
    int   mPht [64];
    bit   mRun;
    int   mInitCycles;
    int   mGhr;
    trk_t mE, mM;
    trk_t noTrk = '{p: 0, idx: 0, v: 0};

    function automatic int idxOf(logic [31:0] pc);
        int i;
        i = int'((pc >> 2) & 32'd63);
`ifdef BP_GSHARE_EN
        i = i ^ mGhr;
`endif
        return i;
    endfunction

    task automatic chk(string tag, logic got, logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chkI(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mInitCycles = 0; mGhr = 0;
        mE = noTrk; mM = noTrk;
    endtask

    // Check outputs mid-cycle, advance the model, then cross one clock edge.
    task automatic step(string tag);
        int   i;
        bit   ep;
        trk_t nE, nM;
        #2;
        i  = idxOf(pcD);
        ep = branchD && mRun && (mPht[i] >= 2);
        chk({tag, ".pred"}, pred_takeD, ep);
        chk({tag, ".succ"}, succM, !(branchM && mM.v) || (mM.p == actual_takeM));
        chk({tag, ".busy"}, init_busy, !mRun);
        nE = flushE ? noTrk : stallE ? mE : '{p: ep, idx: i, v: branchD && mRun};
        nM = flushM ? noTrk : stallM ? mM : mE;
        if (mRun && branchM && mM.v && !stallM) begin
            if (actual_takeM) mPht[mM.idx] = (mPht[mM.idx] == 3) ? 3 : mPht[mM.idx] + 1;
            else              mPht[mM.idx] = (mPht[mM.idx] == 0) ? 0 : mPht[mM.idx] - 1;
            mGhr = ((mGhr << 1) | int'(actual_takeM)) & 63;
        end
        if (!mRun) begin
            mInitCycles++;
            if (mInitCycles == 64) begin
                mRun = 1;
                foreach (mPht[k]) mPht[k] = 1;
            end
        end
        mE = nE; mM = nM;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One branch through D, E, M with no stalls; expected pred/succ given as literals.
    task automatic runBranch(string tag, logic [31:0] pc, logic act, logic expPred, logic expSucc);
        branchD = 1; pcD = pc;
        #1 chk({tag, ".predD"}, pred_takeD, expPred);
        step({tag, ".d"});
        branchD = 0;
        step({tag, ".e"});
        branchM = 1; actual_takeM = act;
        #1 chk({tag, ".succM"}, succM, expSucc);
        step({tag, ".m"});
        branchM = 0; actual_takeM = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        modelReset();
        repeat (2) @(negedge clk);
        #1 chk("rst.busy", init_busy, 1'b1);
        chk("rst.succ", succM, 1'b1);
        @(negedge clk);
        resetn = 1;

        // Init sequence with a branch in flight; not-taken INIT branches report success.
        n = 0;
        branchD = 1; pcD = 32'h100;
        while (init_busy && n < 200) begin
            if (n == 5) begin
                #1 chk("t1.initPred", pred_takeD, 1'b0);
            end
            branchM = (n >= 2); actual_takeM = 0;
            step("t1");
            n++;
        end
        chkI("t1.initCycles", n, 64);
        branchD = 0; branchM = 0;

        // Train up: 01 -> 10 -> 11, then predicted taken.
        runBranch("t2a", 32'h40, 1, 1'b0, 1'b0);
        runBranch("t2b", 32'h40, 1, 1'b1, 1'b1);
        runBranch("t2c", 32'h40, 1, 1'b1, 1'b1);

        // Train down with saturation at 00.
        runBranch("t3a", 32'h40, 0, 1'b1, 1'b0);
        runBranch("t3b", 32'h40, 0, 1'b1, 1'b0);
        runBranch("t3c", 32'h40, 0, 1'b0, 1'b1);
        runBranch("t3d", 32'h40, 0, 1'b0, 1'b1);

        // Stalled M: one update only (00 -> 01).
        branchD = 1; pcD = 32'h40;
        step("t4s.d");
        branchD = 0;
        step("t4s.e");
        branchM = 1; actual_takeM = 1; stallM = 1;
        repeat (3) step("t4s.stall");
        stallM = 0;
        step("t4s.rel");
        branchM = 0; actual_takeM = 0;
        runBranch("t4b", 32'h40, 1, 1'b0, 1'b0);
        // Flushed predicted branch: no training, succM=1.
        branchD = 1; pcD = 32'h40; flushE = 1;
        #1 chk("t4f.predD", pred_takeD, 1'b1);
        step("t4f.d");
        branchD = 0; flushE = 0;
        step("t4f.e");
        branchM = 1; actual_takeM = 0;
        #1 chk("t4f.succM", succM, 1'b1);
        step("t4f.m");
        branchM = 0;
        branchD = 1; pcD = 32'h40;
        #1 chk("t4f.after", pred_takeD, 1'b1);
        step("t4f.look");
        branchD = 0;

        // Async reset with a predicted-taken branch in M.
        branchD = 1; pcD = 32'h40;
        step("t5.d");
        branchD = 0;
        step("t5.e");
        branchM = 1; actual_takeM = 0;
        #1 chk("t5.preRstSucc", succM, 1'b0);
        resetn = 0;
        #1 chk("t5.busy", init_busy, 1'b1);
        chk("t5.succ", succM, 1'b1);
        modelReset();
        @(posedge clk); @(negedge clk);
        resetn = 1; branchM = 0;
        n = 0;
        while (init_busy && n < 200) begin
            step("t5.init");
            n++;
        end
        chkI("t5.initCycles", n, 64);
        for (int k = 0; k < 64; k++) begin
            branchD = 1; pcD = k << 2;
            #1 chk("t5.scan", pred_takeD, 1'b0);
            step("t5.scan");
        end
        branchD = 0;

        // Randomized traffic with a small set of indices so entries collide.
        for (int c = 0; c < 3000; c++) begin
            pcD          = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 15) << 2);
            branchD      = ($urandom % 2) == 0;
            stallE       = ($urandom % 8) == 0;
            flushE       = ($urandom % 16) == 0;
            stallM       = ($urandom % 6) == 0;
            flushM       = ($urandom % 16) == 0;
            branchM      = ($urandom % 4) != 0;
            actual_takeM = ($urandom % 3) != 0;
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
